// File: rtl/iir_pkg.sv
// Shared constants, sample types and round/saturate helper
// for the IIR output conditioning path.
package iir_pkg;

  localparam int IIR_IN_W      = 32;
  localparam int IIR_OUT_W     = 16;
  localparam int IIR_RND_SHIFT = 4;
  localparam int IIR_DECIM_MAX = 4;

  typedef logic signed [IIR_IN_W-1:0]  in_smp_t;
  typedef logic signed [IIR_OUT_W-1:0] out_smp_t;

  typedef struct packed {
    logic              sat;
    logic signed [63:0] val;
  } sr_t;

  // Round half-up by dropping rnd LSBs, then clamp to an ow-bit
  // signed range. val carries the clamped value sign-extended.
  function automatic sr_t sat_round(
    input logic signed [63:0] avg,
    input int                 rnd,
    input int                 ow
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sr_t                res;
    if (rnd > 0)
      r = (avg + (64'sd1 <<< (rnd - 1))) >>> rnd;
    else
      r = avg;
    hi      = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (ow - 1));
    res.sat = 1'b0;
    res.val = r;
    if (r > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/iir_fifo2.sv
// Two-entry synchronous FIFO; head word holds its value when
// drained. Push into a full FIFO is accepted only with a pop.
module iir_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic [1:0]   count;
  logic         pop_ok;

  assign pop_ok = pop && (count != 2'd0);
  assign rdata  = mem0;
  assign full   = (count == 2'd2);
  assign empty  = (count == 2'd0);

  // Shift-style storage: mem0 is always the head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0  <= '0;
      mem1  <= '0;
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            mem0  <= wdata;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop_ok) begin
            mem0 <= wdata;
          end else if (push) begin
            mem1  <= wdata;
            count <= 2'd2;
          end else if (pop_ok) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop_ok) begin
            mem0 <= mem1;
            if (push) mem1 <= wdata;
            else      count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/iir_out_cond.sv
// Boxcar decimate, round/saturate and buffer the biquad output.
// Optional saturation counter: define IIR_OUT_SAT_CNT_EN.
module iir_out_cond
  import iir_pkg::*;
#(
  parameter int IN_WIDTH       = IIR_IN_W,
  parameter int OUT_WIDTH      = IIR_OUT_W,
  parameter int RND_SHIFT      = IIR_RND_SHIFT,
  parameter int DECIM_LOG2_MAX = IIR_DECIM_MAX
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic [3:0]                  decim_log2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
`ifdef IIR_OUT_SAT_CNT_EN
  output logic [15:0]                 sat_count,
  input  logic                        sat_count_clr,
`endif
  output logic                        overrun
);

  localparam int ACC_W = IN_WIDTH + DECIM_LOG2_MAX;
  localparam int CNT_W = (DECIM_LOG2_MAX > 0) ? DECIM_LOG2_MAX : 1;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] avg_reg;
  logic                    avg_vld;
  logic [CNT_W-1:0]        cnt;
  logic [3:0]              d_blk;
  logic [3:0]              d_clip;
  logic [3:0]              d_eff;
  logic                    last;
  sr_t                     sr;
  logic [OUT_WIDTH:0]      wword;
  logic [OUT_WIDTH:0]      rword;
  logic                    full;
  logic                    empty;
  logic                    pop;
  logic                    push_ok;

  // The block exponent is taken live on a block's first sample.
  always_comb begin
    d_clip = decim_log2;
    if (32'(decim_log2) > DECIM_LOG2_MAX)
      d_clip = 4'(DECIM_LOG2_MAX);
    d_eff = (cnt == '0) ? d_clip : d_blk;
    sum   = acc + ACC_W'(in_data);
    last  = (32'(cnt) == (32'd1 << d_eff) - 32'd1);
  end

  // Stage 1: accumulate a block and emit its floor average.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      d_blk   <= '0;
      avg_reg <= '0;
      avg_vld <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      if (in_valid) begin
        if (cnt == '0) d_blk <= d_clip;
        if (last) begin
          avg_reg <= sum >>> d_eff;
          avg_vld <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Stage 2: round and clamp the average to the bus width.
  always_comb begin
    sr    = sat_round(64'(avg_reg), RND_SHIFT, OUT_WIDTH);
    wword = {sr.sat, OUT_WIDTH'(sr.val)};
  end

  assign pop     = !empty && out_ready;
  assign push_ok = avg_vld && (!full || pop);

  iir_fifo2 #(
    .W (OUT_WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (avg_vld),
    .wdata (wword),
    .pop   (pop),
    .rdata (rword),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_data  = rword[OUT_WIDTH-1:0];
  assign out_sat   = rword[OUT_WIDTH];

  // Flag a result lost to a full buffer with no pop.
  always_ff @(posedge clk) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= avg_vld && full && !pop;
  end

`ifdef IIR_OUT_SAT_CNT_EN
  // Count saturated pushes; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || sat_count_clr)
      sat_count <= '0;
    else if (push_ok && sr.sat && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end
`else
  logic unused_push_ok;
  assign unused_push_ok = push_ok;
`endif

endmodule

// File: tb/tb_iir_out_cond.sv
// Scoreboard bench for iir_out_cond: expected words are queued
// when stimulus is driven and compared as the DUT pops them.
module tb_iir_out_cond;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [31:0] in_data;
  logic [3:0]         decim_log2;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic               overrun;
`ifdef IIR_OUT_SAT_CNT_EN
  logic [15:0]        sat_count;
  logic               sat_count_clr;
`endif

  int          errors = 0;
  int          checks = 0;
  int          ovr_seen = 0;
  logic [16:0] q[$];

  always #5 clk = ~clk;

  iir_out_cond dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .decim_log2    (decim_log2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_sat       (out_sat),
`ifdef IIR_OUT_SAT_CNT_EN
    .sat_count     (sat_count),
    .sat_count_clr (sat_count_clr),
`endif
    .overrun       (overrun)
  );

  task automatic chk(input string tag, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic expect_word(input int v, input bit s);
    logic [15:0] w;
    w = v[15:0];
    q.push_back({s, w});
  endtask

  task automatic send(input logic signed [31:0] x);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && overrun) ovr_seen++;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {out_sat, out_data}, -1);
      end else begin
        chk("out_word", {out_sat, out_data}, q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    decim_log2 = 4'd0;
    out_ready  = 1'b1;
`ifdef IIR_OUT_SAT_CNT_EN
    sat_count_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_ovr", overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: pass-through rounding and latency
    expect_word(2, 0);
    send(24);
    @(negedge clk);
    chk("lat_n1", out_valid, 0);
    @(negedge clk);
    chk("lat_n2", out_valid, 1);
    @(posedge clk);
    #1;
    expect_word(-1, 0);
    send(-24);
    drain();

    // 2: saturation both ways
    expect_word(32'h7FFF, 1);
    send(32'h7FFFFFFF);
    expect_word(32'h8000, 1);
    send(32'h80000000);
    drain();
`ifdef IIR_OUT_SAT_CNT_EN
    chk("sat_count", sat_count, 2);
    sat_count_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_count_clr = 1'b0;
    chk("sat_count_clr", sat_count, 0);
`endif

    // 3: decimate by 4, single output
    decim_log2 = 4'd2;
    send(16);
    send(32);
    send(48);
    repeat (3) @(posedge clk);
    #1;
    chk("no_early", out_valid, 0);
    expect_word(3, 0);
    send(64);
    drain();

    // 4: overrun with stalled consumer
    decim_log2 = 4'd0;
    out_ready  = 1'b0;
    expect_word(1, 0);
    send(16);
    expect_word(2, 0);
    send(32);
    send(48);
    @(negedge clk);
    chk("ovr_n1", overrun, 0);
    @(negedge clk);
    chk("ovr_n2", overrun, 1);
    @(negedge clk);
    chk("ovr_n3", overrun, 0);
    chk("hold_valid", out_valid, 1);
    chk("hold_data", out_data, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("drained_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // 5: decim change mid-block is deferred
    decim_log2 = 4'd2;
    send(16);
    send(16);
    decim_log2 = 4'd0;
    send(48);
    expect_word(2, 0);
    send(48);
    expect_word(4, 0);
    send(64);
    expect_word(5, 0);
    send(80);
    drain();

    // 6: reset discards a partial block
    decim_log2 = 4'd2;
    send(100);
    send(100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_data", out_data, 0);
    chk("rst2_sat", out_sat, 0);
    chk("rst2_ovr", overrun, 0);
    @(posedge clk);
    #1;
    send(16);
    send(16);
    send(16);
    expect_word(1, 0);
    send(16);
    drain();

    repeat (4) @(posedge clk);
    #1;
    chk("ovr_total", ovr_seen, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
